// File: rtl/ltc2195_spi_responder_if.sv
// SPI pin bundle between the FPGA initiator (master) and the emulated LTC2195 (slave).
interface ltc2195_spi_responder_if;
    logic scs;
    logic sck;
    logic sdi;
    logic sdo;

    modport master (output scs, output sck, output sdi, input sdo);
    modport slave  (input scs, input sck, input sdi, output sdo);
endinterface

// File: rtl/ltc2195_spi_responder.sv
// LTC2195 SPI configuration-port emulator: 16-bit R/W frames into a five-register map.
// Define LTC2195_SPI_READBACK_EN to build the sdo readback path.
module ltc2195_spi_responder #(
    parameter logic [7:0] A1_DEFAULT = 8'h00,
    parameter logic [7:0] A2_DEFAULT = 8'h00,
    parameter logic [7:0] A3_DEFAULT = 8'h00,
    parameter logic [7:0] A4_DEFAULT = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ltc2195_spi_responder_if.slave        spi,
    output logic [7:0]                    reg_a1,
    output logic [7:0]                    reg_a2,
    output logic [7:0]                    reg_a3,
    output logic [7:0]                    reg_a4,
    output logic                          wr_strobe,
    output logic [6:0]                    wr_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0] scsSync_q;
    logic       scsPrev_q;
    logic [2:0] sckSync_q;
    logic [1:0] sdiSync_q;

    logic       scsS, scsFall, sckRise, sckFall, sdiS;

    logic [1:0] state_q,   state_d;
    logic [3:0] bitCnt_q,  bitCnt_d;
    logic [6:0] shift_q,   shift_d;
    logic       rw_q,      rw_d;
    logic [6:0] addr_q,    addr_d;
    logic [7:0] regA1_q,   regA1_d;
    logic [7:0] regA2_q,   regA2_d;
    logic [7:0] regA3_q,   regA3_d;
    logic [7:0] regA4_q,   regA4_d;
    logic       wrStrobe_q, wrStrobe_d;
    logic [6:0] wrAddr_q,  wrAddr_d;
    logic [7:0] dataByte;
    logic [6:0] cmdAddr;

    // scsPrev resets low so a frame already in flight at reset release is never seen as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scsSync_q <= 2'b00;
            scsPrev_q <= 1'b0;
            sckSync_q <= 3'b000;
            sdiSync_q <= 2'b00;
        end else begin
            scsSync_q <= {scsSync_q[0], spi.scs};
            scsPrev_q <= scsSync_q[1];
            sckSync_q <= {sckSync_q[1:0], spi.sck};
            sdiSync_q <= {sdiSync_q[0], spi.sdi};
        end
    end

    assign scsS     = scsSync_q[1];
    assign scsFall  = scsPrev_q & ~scsS;
    assign sckRise  = sckSync_q[1] & ~sckSync_q[2];
    assign sckFall  = ~sckSync_q[1] & sckSync_q[2];
    assign sdiS     = sdiSync_q[1];
    assign dataByte = {shift_q, sdiS};
    assign cmdAddr  = {shift_q[5:0], sdiS};

`ifdef LTC2195_SPI_READBACK_EN
    logic [7:0] rdShift_q, rdShift_d;
    logic       sdo_q,     sdo_d;
    logic [7:0] rdValue;

    always_comb begin
        case (cmdAddr)
            7'h01:   rdValue = regA1_q;
            7'h02:   rdValue = regA2_q;
            7'h03:   rdValue = regA3_q;
            7'h04:   rdValue = regA4_q;
            default: rdValue = 8'h00;
        endcase
    end

    // Readback is latched at the 8th rising edge and shifted out MSB first on falling edges.
    always_comb begin
        rdShift_d = rdShift_q;
        sdo_d     = sdo_q;
        if (scsS || state_q == IDLE || state_q == HOLD) begin
            sdo_d = 1'b0;
        end else if (state_q == CMD && sckRise && bitCnt_q == 4'd7) begin
            rdShift_d = rdValue;
        end else if (state_q == DATA) begin
            if (sckRise && bitCnt_q == 4'd15) begin
                sdo_d = 1'b0;
            end else if (sckFall && rw_q) begin
                sdo_d     = rdShift_q[7];
                rdShift_d = {rdShift_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdShift_q <= 8'h00;
            sdo_q     <= 1'b0;
        end else begin
            rdShift_q <= rdShift_d;
            sdo_q     <= sdo_d;
        end
    end

    assign spi.sdo = sdo_q & ~scsS;
`else
    assign spi.sdo = 1'b0;
`endif

    // Frame decoder; a high chip select overrides every state and discards the frame.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        regA1_d    = regA1_q;
        regA2_d    = regA2_q;
        regA3_d    = regA3_q;
        regA4_d    = regA4_q;
        wrStrobe_d = 1'b0;
        wrAddr_d   = wrAddr_q;
        if (scsS) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (scsFall) begin
                    state_d  = CMD;
                    bitCnt_d = 4'd0;
                    shift_d  = 7'd0;
                end
                CMD: if (sckRise) begin
                    shift_d  = dataByte[6:0];
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd7) begin
                        rw_d    = shift_q[6];
                        addr_d  = cmdAddr;
                        state_d = DATA;
                    end
                end
                DATA: if (sckRise) begin
                    shift_d  = dataByte[6:0];
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd15) begin
                        state_d = HOLD;
                        if (!rw_q) begin
                            case (addr_q)
                                7'h00: if (dataByte[7]) begin
                                    regA1_d    = A1_DEFAULT;
                                    regA2_d    = A2_DEFAULT;
                                    regA3_d    = A3_DEFAULT;
                                    regA4_d    = A4_DEFAULT;
                                    wrStrobe_d = 1'b1;
                                    wrAddr_d   = 7'h00;
                                end
                                7'h01: begin regA1_d = dataByte; wrStrobe_d = 1'b1; wrAddr_d = addr_q; end
                                7'h02: begin regA2_d = dataByte; wrStrobe_d = 1'b1; wrAddr_d = addr_q; end
                                7'h03: begin regA3_d = dataByte; wrStrobe_d = 1'b1; wrAddr_d = addr_q; end
                                7'h04: begin regA4_d = dataByte; wrStrobe_d = 1'b1; wrAddr_d = addr_q; end
                                default: ;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 7'd0;
            rw_q       <= 1'b0;
            addr_q     <= 7'd0;
            regA1_q    <= A1_DEFAULT;
            regA2_q    <= A2_DEFAULT;
            regA3_q    <= A3_DEFAULT;
            regA4_q    <= A4_DEFAULT;
            wrStrobe_q <= 1'b0;
            wrAddr_q   <= 7'd0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            regA1_q    <= regA1_d;
            regA2_q    <= regA2_d;
            regA3_q    <= regA3_d;
            regA4_q    <= regA4_d;
            wrStrobe_q <= wrStrobe_d;
            wrAddr_q   <= wrAddr_d;
        end
    end

    assign reg_a1    = regA1_q;
    assign reg_a2    = regA2_q;
    assign reg_a3    = regA3_q;
    assign reg_a4    = regA4_q;
    assign wr_strobe = wrStrobe_q;
    assign wr_addr   = wrAddr_q;

endmodule

// File: tb/tb_ltc2195_spi_responder.sv
// Scoreboard bench for ltc2195_spi_responder: SPI master driver, register-map model, strobe/readback monitor.
module tb_ltc2195_spi_responder;

    localparam int PERIOD = 10;
    localparam int HALF   = 5;
    localparam logic [7:0] DEF1 = 8'h11;
    localparam logic [7:0] DEF2 = 8'h22;
    localparam logic [7:0] DEF3 = 8'h33;
    localparam logic [7:0] DEF4 = 8'h44;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] r1, r2, r3, r4;
    } wrExp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] reg_a1, reg_a2, reg_a3, reg_a4;
    logic       wr_strobe;
    logic [6:0] wr_addr;

    ltc2195_spi_responder_if spi ();

    ltc2195_spi_responder #(
        .A1_DEFAULT(DEF1), .A2_DEFAULT(DEF2), .A3_DEFAULT(DEF3), .A4_DEFAULT(DEF4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi),
        .reg_a1(reg_a1), .reg_a2(reg_a2), .reg_a3(reg_a3), .reg_a4(reg_a4),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    int         nCompare = 0;
    int         nFail    = 0;
    logic [7:0] mdl [1:4];
    wrExp_t     wrExpQ [$];
    logic [7:0] rdExpQ [$];
    logic [7:0] rdActQ [$];
    time        t16 = 0;

    initial clk = 1'b0;
    always #(HALF) clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompare++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] modelRead(input logic [6:0] addr);
        if (addr >= 7'd1 && addr <= 7'd4) return mdl[addr[2:0]];
        return 8'h00;
    endfunction

    task automatic modelReset();
        mdl[1] = DEF1; mdl[2] = DEF2; mdl[3] = DEF3; mdl[4] = DEF4;
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_reg_a1"}, 32'(reg_a1), 32'(mdl[1]));
        checkOutput({tag, "_reg_a2"}, 32'(reg_a2), 32'(mdl[2]));
        checkOutput({tag, "_reg_a3"}, 32'(reg_a3), 32'(mdl[3]));
        checkOutput({tag, "_reg_a4"}, 32'(reg_a4), 32'(mdl[4]));
    endtask

    // One SPI frame at SCK = clk/10; nbits < 16 aborts early, rstAt >= 0 pulses reset before that bit.
    task automatic applyStimulus(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                                 input int nbits, input int rstAt);
        logic [15:0] frame;
        logic [7:0]  rx;
        bit          full;
        wrExp_t      e;
        frame = {rw, addr, data};
        rx    = 8'h00;
        full  = (nbits == 16) && (rstAt < 0);
        if (full && rw) begin
`ifdef LTC2195_SPI_READBACK_EN
            rdExpQ.push_back(modelRead(addr));
`else
            rdExpQ.push_back(8'h00);
`endif
        end
        if (full && !rw) begin
            if (addr >= 7'd1 && addr <= 7'd4) begin
                mdl[addr[2:0]] = data;
                e = '{addr, mdl[1], mdl[2], mdl[3], mdl[4]};
                wrExpQ.push_back(e);
            end else if (addr == 7'd0 && data[7]) begin
                modelReset();
                e = '{7'd0, mdl[1], mdl[2], mdl[3], mdl[4]};
                wrExpQ.push_back(e);
            end
        end
        spi.scs = 1'b0;
        waitClk(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi.sdi = frame[15 - i];
            if (i == rstAt) begin
                rst_n = 1'b0;
                modelReset();
                waitClk(2);
                checkRegs("midreset");
                checkOutput("midreset_sdo", 32'(spi.sdo), 32'd0);
                checkOutput("midreset_strobe", 32'(wr_strobe), 32'd0);
                checkOutput("midreset_wr_addr", 32'(wr_addr), 32'd0);
                rst_n = 1'b1;
                waitClk(HALF - 2);
            end else begin
                waitClk(HALF);
            end
            if (i >= 8) rx = {rx[6:0], spi.sdo};
            spi.sck = 1'b1;
            if (i == 15) t16 = $time;
            waitClk(HALF);
            spi.sck = 1'b0;
        end
        waitClk(HALF);
        spi.scs = 1'b1;
        spi.sdi = 1'b0;
        waitClk(10);
        if (full && rw) rdActQ.push_back(rx);
        waitClk(2);
        checkRegs("frame_end");
    endtask

    // Monitor: each strobe cycle pops one expected commit; each captured readback pops one expected byte.
    initial begin
        wrExp_t     e;
        logic [7:0] a, x;
        forever begin
            @(negedge clk);
            if (rst_n && wr_strobe) begin
                checkOutput("strobe_expected", 32'(wrExpQ.size() > 0), 32'd1);
                if (wrExpQ.size() > 0) begin
                    e = wrExpQ.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
                    checkOutput("strobe_reg_a1", 32'(reg_a1), 32'(e.r1));
                    checkOutput("strobe_reg_a2", 32'(reg_a2), 32'(e.r2));
                    checkOutput("strobe_reg_a3", 32'(reg_a3), 32'(e.r3));
                    checkOutput("strobe_reg_a4", 32'(reg_a4), 32'(e.r4));
                    checkOutput("strobe_latency", 32'($time - t16), 32'(3 * PERIOD + HALF - 1));
                end
            end
            while (rdActQ.size() > 0) begin
                a = rdActQ.pop_front();
                checkOutput("read_expected", 32'(rdExpQ.size() > 0), 32'd1);
                if (rdExpQ.size() > 0) begin
                    x = rdExpQ.pop_front();
                    checkOutput("sdo_readback", 32'(a), 32'(x));
                end
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] addrList [8];
        logic [6:0] ra;
        logic [7:0] rd;
        bit         rrw;
        int         nb;
        addrList = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h10, 7'h7F, 7'h05};
        rst_n   = 1'b0;
        spi.scs = 1'b1;
        spi.sck = 1'b0;
        spi.sdi = 1'b0;
        modelReset();
        waitClk(3);
        checkRegs("reset");
        checkOutput("reset_sdo", 32'(spi.sdo), 32'd0);
        checkOutput("reset_strobe", 32'(wr_strobe), 32'd0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
        rst_n = 1'b1;
        waitClk(5);

        $display("[TB] directed frames");
        applyStimulus(1'b0, 7'h01, 8'hA5, 16, -1);
        applyStimulus(1'b1, 7'h01, 8'h00, 16, -1);
        applyStimulus(1'b0, 7'h03, 8'h3C, 16, -1);
        applyStimulus(1'b0, 7'h04, 8'hF0, 16, -1);
        applyStimulus(1'b0, 7'h00, 8'h80, 16, -1);
        applyStimulus(1'b1, 7'h00, 8'h00, 16, -1);
        applyStimulus(1'b0, 7'h02, 8'h55, 12, -1);
        applyStimulus(1'b0, 7'h02, 8'h5A, 16, -1);
        applyStimulus(1'b1, 7'h02, 8'hFF, 16, -1);
        applyStimulus(1'b0, 7'h10, 8'h77, 16, -1);
        applyStimulus(1'b1, 7'h10, 8'h00, 16, -1);
        applyStimulus(1'b0, 7'h01, 8'hC3, 16, 10);
        applyStimulus(1'b0, 7'h01, 8'h96, 16, -1);
        applyStimulus(1'b1, 7'h01, 8'h00, 16, -1);

        $display("[TB] random frames");
        for (int k = 0; k < 30; k++) begin
            ra  = addrList[$urandom_range(0, 7)];
            rd  = 8'($urandom);
            rrw = 1'($urandom_range(0, 1));
            nb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : 16;
            if (ra == 7'h00 && !rrw) rd[7] = 1'b1;
            applyStimulus(rrw, ra, rd, nb, -1);
        end

        waitClk(5);
        checkOutput("leftover_writes", 32'(wrExpQ.size()), 32'd0);
        checkOutput("leftover_reads", 32'(rdExpQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
        $finish;
    end

endmodule
